// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer for the async FIFO: drains the FIFO read port and re-presents words
// as a valid/ready stream through a 2-entry buffer that hides the one-cycle read latency.
module async_fifo_rd_stream #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_rd,
    input  logic             ainit,
    input  logic             rd_en,
    input  logic             fifo_empty,
    input  logic [SIZE-1:0]  data_rd,
    output logic             req_rd,
    output logic             out_valid,
    output logic [SIZE-1:0]  out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic             inflight_q;
    logic [SIZE-1:0]  buf0_q, buf0_d;
    logic [SIZE-1:0]  buf1_q, buf1_d;
    logic [CNT_W-1:0] rd_count_q;
    logic             pop;
    logic [1:0]       credit;

    assign out_valid = (buf_cnt_q != 2'd0);
    assign out_data  = buf0_q;
    assign rd_count  = rd_count_q;
    assign pop       = out_valid & out_ready;
    assign credit    = buf_cnt_q + {1'b0, inflight_q};

    always_ff @(posedge clk_rd or posedge ainit) begin
        if (ainit) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (rd_en) state_d = StRun;
            StRun:   if (!rd_en) state_d = StDrain;
            StDrain: begin
                if (rd_en) begin
                    state_d = StRun;
                end else if (!inflight_q && (buf_cnt_q == 2'd0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Credit counts buffered plus in-flight words; a same-cycle pop frees one slot.
    always_comb begin
        req_rd = (state_q == StRun) && !fifo_empty
                 && ({1'b0, credit} < (3'd2 + {2'b00, pop}));
        busy   = (state_q != StIdle);
    end

    // Pop shifts the head out first, then returning read data lands in the new tail slot.
    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        if (pop) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_d = data_rd;
            end else begin
                buf1_d = data_rd;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_rd or posedge ainit) begin
        if (ainit) begin
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            rd_count_q <= '0;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= req_rd;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            if (pop) begin
                rd_count_q <= rd_count_q + 1'b1;
            end
        end
    end

    assert property (@(posedge clk_rd) disable iff (ainit)
                     !(inflight_q && (buf_cnt_q == 2'd2) && !pop))
        else $error("async_fifo_rd_stream: output buffer overflow");

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Scoreboard bench for async_fifo_rd_stream: a FIFO model feeds the DUT, every pushed word is
// queued as expected output and a monitor checks delivered words and the delivered count.
module tb_async_fifo_rd_stream;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk_rd = 1'b0;
    logic             ainit;
    logic             rd_en;
    logic             fifo_empty;
    logic [SIZE-1:0]  data_rd;
    logic             req_rd;
    logic             out_valid;
    logic [SIZE-1:0]  out_data;
    logic             out_ready;
    logic [CNT_W-1:0] rd_count;
    logic             busy;

    async_fifo_rd_stream #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk_rd     (clk_rd),
        .ainit      (ainit),
        .rd_en      (rd_en),
        .fifo_empty (fifo_empty),
        .data_rd    (data_rd),
        .req_rd     (req_rd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .rd_count   (rd_count),
        .busy       (busy)
    );

    always #5 clk_rd = ~clk_rd;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: stimulus owns exp_wr, monitor owns exp_rd.
    logic [SIZE-1:0] exp_mem [64];
    int              exp_wr = 0;
    int              exp_rd = 0;
    logic [CNT_W-1:0] mon_cnt = '0;

    logic [SIZE-1:0] fifo_q [$];

    int cyc = 0, n_req = 0, n_pop = 0, first_req = 0, first_pop = 0, last_pop = 0;

    always @(negedge clk_rd) begin
        if (ainit) begin
            exp_rd  = exp_wr;
            mon_cnt = '0;
        end else if (out_valid && out_ready) begin
            checks = checks + 2;
            if (exp_rd == exp_wr) begin
                failures = failures + 1;
                $display("FAIL unexpected_word: got %02h with no word outstanding", out_data);
            end else begin
                if (out_data !== exp_mem[exp_rd % 64]) begin
                    failures = failures + 1;
                    $display("FAIL word_order: got %02h expected %02h",
                             out_data, exp_mem[exp_rd % 64]);
                end
                exp_rd = exp_rd + 1;
            end
            if (rd_count !== mon_cnt) begin
                failures = failures + 1;
                $display("FAIL rd_count_at_pop: got %0d expected %0d", rd_count, mon_cnt);
            end
            mon_cnt = mon_cnt + 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [SIZE-1:0] w);
        fifo_q.push_back(w);
        exp_mem[exp_wr % 64] = w;
        exp_wr = exp_wr + 1;
        fifo_empty = 1'b0;
    endtask

    task automatic clear_stats();
        n_req = 0;
        n_pop = 0;
    endtask

    // One clock: sample handshakes before the edge, model the FIFO read port after it.
    task automatic cycle();
        logic req_seen;
        @(negedge clk_rd);
        req_seen = req_rd;
        if (out_valid && out_ready) begin
            if (n_pop == 0) first_pop = cyc;
            last_pop = cyc;
            n_pop = n_pop + 1;
        end
        if (req_seen) begin
            if (n_req == 0) first_req = cyc;
            n_req = n_req + 1;
        end
        @(posedge clk_rd);
        #1;
        if (req_seen && fifo_q.size() > 0) data_rd = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        cyc = cyc + 1;
    endtask

    task automatic run_drained(input string name, input bit toggle);
        int n = 0;
        while (exp_rd != exp_wr && n < 200) begin
            if (toggle) out_ready = ~out_ready;
            cycle();
            n = n + 1;
        end
        if (exp_rd != exp_wr) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s_timeout: got %0d words outstanding expected 0", name, exp_wr - exp_rd);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            cycle();
            n = n + 1;
        end
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        ainit = 1'b1;
        fifo_q.delete();
        fifo_empty = 1'b1;
        data_rd = '0;
        cycle();
        cycle();
        ainit = 1'b0;
    endtask

    initial begin
        ainit = 1'b1;
        rd_en = 1'b0;
        out_ready = 1'b0;
        fifo_empty = 1'b1;
        data_rd = '0;
        do_reset();

        chk("reset_req_rd", {31'd0, req_rd}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", {24'd0, out_data}, 32'd0);
        chk("reset_rd_count", {28'd0, rd_count}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Three words at full rate.
        push(8'h11); push(8'h22); push(8'h33);
        clear_stats();
        rd_en = 1'b1;
        out_ready = 1'b1;
        run_drained("t1", 1'b0);
        repeat (3) cycle();
        chk("t1_req_count", n_req, 3);
        chk("t1_latency", first_pop - first_req, 2);
        chk("t1_back_to_back", last_pop - first_pop, 2);
        chk("t1_rd_count", {28'd0, rd_count}, 32'd3);
        rd_en = 1'b0;
        wait_idle("t1");

        // Downstream stall: only two reads may be outstanding.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        clear_stats();
        rd_en = 1'b1;
        repeat (6) cycle();
        chk("t2_stall_req_count", n_req, 2);
        chk("t2_stall_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_stall_head", {24'd0, out_data}, 32'h40);
        out_ready = 1'b1;
        run_drained("t2", 1'b0);
        chk("t2_pop_count", n_pop, 8);
        chk("t2_no_gaps", last_pop - first_pop, 7);
        rd_en = 1'b0;
        wait_idle("t2");

        // Toggling ready, 16 words; count wraps 11+16 -> 11 with a 4-bit counter.
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
        clear_stats();
        out_ready = 1'b0;
        rd_en = 1'b1;
        run_drained("t3", 1'b1);
        chk("t3_pop_count", n_pop, 16);
        chk("t3_rd_count", {28'd0, rd_count}, 32'd11);
        rd_en = 1'b0;
        out_ready = 1'b0;
        wait_idle("t3");

        // Drop rd_en with one word buffered and one in flight.
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        clear_stats();
        rd_en = 1'b1;
        repeat (3) cycle();
        rd_en = 1'b0;
        cycle();
        chk("t4_drain_busy", {31'd0, busy}, 32'd1);
        chk("t4_drain_req", {31'd0, req_rd}, 32'd0);
        out_ready = 1'b1;
        wait_idle("t4");
        chk("t4_pop_count", n_pop, 2);
        chk("t4_req_count", n_req, 2);

        // Reset mid-stream: one buffered, one in flight.
        out_ready = 1'b0;
        push(8'h70);
        rd_en = 1'b1;
        repeat (3) cycle();
        ainit = 1'b1;
        #1;
        chk("t5_reset_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_reset_rd_count", {28'd0, rd_count}, 32'd0);
        chk("t5_reset_busy", {31'd0, busy}, 32'd0);
        do_reset();
        push(8'hA5);
        clear_stats();
        out_ready = 1'b1;
        run_drained("t5", 1'b0);
        chk("t5_pop_count", n_pop, 1);
        chk("t5_rd_count", {28'd0, rd_count}, 32'd1);
        rd_en = 1'b0;
        wait_idle("t5");

        // 17 words from a cleared count: 15 -> 0 -> 1.
        do_reset();
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        clear_stats();
        rd_en = 1'b1;
        out_ready = 1'b1;
        run_drained("t6", 1'b0);
        chk("t6_pop_count", n_pop, 17);
        chk("t6_rd_count_wrap", {28'd0, rd_count}, 32'd1);
        rd_en = 1'b0;
        wait_idle("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
